// File: rtl/trn_cdc_sync.sv
// trn_cdc_sync: carries the TRN status word into the sys_clk domain through
// a three-stage shift chain plus a coherence filter, and registers the
// flow-control select before it reaches the PCIe core.
module trn_cdc_sync #(
  parameter int STAT_W = 32,
  parameter int SEL_W  = 3,
  parameter logic [STAT_W-1:0] STAT_RST = 'h1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [SEL_W-1:0]  sys__trn_fc_sel,
  output logic [SEL_W-1:0]  trn__trn_fc_sel,
  input  logic [STAT_W-1:0] trn__stat_trn,
  output logic [STAT_W-1:0] sys__stat_trn
);

  // Power-up values match the reset values, so the link reads "down"
  // before the first reset edge.
  logic [STAT_W-1:0] s1 = STAT_RST;
  logic [STAT_W-1:0] s2 = STAT_RST;
  logic [STAT_W-1:0] s3 = STAT_RST;
  logic [STAT_W-1:0] stat_q = STAT_RST;
  logic [SEL_W-1:0]  sel_q = '0;

  // Shift chain; s1 is the only flop that samples the asynchronous word.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= STAT_RST;
      s2 <= STAT_RST;
      s3 <= STAT_RST;
    end else begin
      s1 <= trn__stat_trn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Output only accepts a word seen identically in two consecutive stages,
  // so a word torn across bits by the crossing never appears downstream.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stat_q <= STAT_RST;
    end else if (s2 == s3) begin
      stat_q <= s3;
    end
  end

  // Select is already in this domain; a flop keeps the core's input glitch-free.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= sys__trn_fc_sel;
    end
  end

  assign sys__stat_trn   = stat_q;
  assign trn__trn_fc_sel = sel_q;

endmodule

// File: tb/tb_trn_cdc_sync.sv
// tb_trn_cdc_sync: directed and random stimulus against a sample-history
// reference model of the status filter and select register.
module tb_trn_cdc_sync;

  localparam logic [31:0] STAT_RST = 32'h0000_0001;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [2:0]  sys__trn_fc_sel = 3'd0;
  logic [2:0]  trn__trn_fc_sel;
  logic [31:0] trn__stat_trn = 32'h0;
  logic [31:0] sys__stat_trn;

  int checks = 0;
  int errors = 0;

  // Reference state: history of words sampled at each edge (newest last),
  // the expected output word and expected select.
  logic [31:0] samples[$];
  logic [31:0] exp_stat = STAT_RST;
  logic [2:0]  exp_sel = 3'd0;

  trn_cdc_sync dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .sys__trn_fc_sel (sys__trn_fc_sel),
    .trn__trn_fc_sel (trn__trn_fc_sel),
    .trn__stat_trn   (trn__stat_trn),
    .sys__stat_trn   (sys__stat_trn)
  );

  // 10 ns clock.
  always #5 sys_clk = ~sys_clk;

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h",
               tag, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  // The output adopts a word once the two samples taken 2 and 3 edges ago
  // agree; a reset makes the last three samples read as the reset word.
  task automatic applyStimulus(input logic rst, input logic [31:0] stat,
                               input logic [2:0] sel);
    sys_rst = rst;
    trn__stat_trn = stat;
    sys__trn_fc_sel = sel;
    @(posedge sys_clk);
    if (rst) begin
      exp_stat = STAT_RST;
      exp_sel = 3'd0;
      repeat (3) samples.push_back(STAT_RST);
    end else begin
      if (samples[$-1] == samples[$-2]) exp_stat = samples[$-2];
      samples.push_back(stat);
      exp_sel = sel;
    end
    while (samples.size() > 6) void'(samples.pop_front());
    #1;
    checkOutput("stat", sys__stat_trn, exp_stat);
    checkOutput("sel", {29'd0, trn__trn_fc_sel}, {29'd0, exp_sel});
  endtask

  task automatic holdStat(input logic [31:0] stat, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, stat, sys__trn_fc_sel);
  endtask

  initial begin
    logic [31:0] pool[6];
    logic [31:0] val;
    int hold;
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'hA5A5_A5A5; pool[4] = 32'h5A5A_5A5A; pool[5] = 32'h8000_0000;
    repeat (3) samples.push_back(STAT_RST);

    #1;
    checkOutput("init_stat", sys__stat_trn, STAT_RST);
    checkOutput("init_sel", {29'd0, trn__trn_fc_sel}, 32'd0);

    // Reset with all-ones inputs, then release.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd7);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd7);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'hFFFF_FFFF, 3'd7);

    // Select sweep.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'hFFFF_FFFF, 3'(i));

    // Link bit drop.
    holdStat(32'h1, 5);
    holdStat(32'h0, 6);

    // Alternating words never cohere, then a steady word passes.
    for (int i = 0; i < 8; i++)
      holdStat((i % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A, 1);
    holdStat(32'h1234_5678, 6);

    // Single-cycle glitch.
    holdStat(32'h0, 4);
    holdStat(32'h8000_0000, 1);
    holdStat(32'h0, 5);

    // Reset two edges after a change.
    holdStat(32'hDEAD_BEEF, 2);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 3'd5);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 3'd5);
    holdStat(32'hDEAD_BEEF, 6);

    // Random runs of varying length, occasional reset.
    for (int n = 0; n < 150; n++) begin
      val = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 5)];
      hold = $urandom_range(1, 4);
      for (int i = 0; i < hold; i++)
        applyStimulus(($urandom_range(0, 40) == 0), val, 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
